// File: rtl/i2s_stereo_tx.sv
// Stereo I2S transmitter: frame FIFO, BClk/LRClk generation, serialiser.
// Define LEFT_JUSTIFIED_EN for left-justified output instead of I2S.
module i2s_stereo_tx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 2
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             Enable,
    input  logic                             In_Valid,
    input  logic [2*DATA_W-1:0]              In_Data,
    output logic                             In_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  Fifo_Level,
    output logic                             BClk,
    output logic                             LRClk,
    output logic                             SData,
    output logic                             Underrun,
    output logic [1:0]                       State_Dbg
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_B   = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] SLOT_B   = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] DATA_B   = CNT_W'(DATA_W);
    localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(BCLK_DIV - 1);

`ifdef LEFT_JUSTIFIED_EN
    localparam logic LJ_MODE = 1'b1;
`else
    localparam logic LJ_MODE = 1'b0;
`endif
    localparam logic LR_IDLE = ~LJ_MODE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_W-1:0] head;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level, level_nxt;
    logic                fifo_empty, push, pop;

    logic [DIV_W-1:0]    div;
    logic [CNT_W-1:0]    b, b_nxt, k;
    logic [DATA_W-1:0]   left_sr, right_sr;
    logic [DATA_W-1:0]   left_src, right_src;
    logic [DATA_W-1:0]   left_nxt, right_nxt;
    logic                bclk_fall, launch, to_idle, frame_launch;
    logic                slot_r, bit_on, sdata_bit;

    assign State_Dbg  = state;
    assign Fifo_Level = level;
    assign head       = mem[rd_ptr];
    assign fifo_empty = (level == '0);
    assign push       = In_Valid && In_Ready;
    assign pop        = frame_launch && !fifo_empty;

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Launches happen on entry and on every BClk falling edge; DRAIN
    // suppresses the launch that would start a new frame.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        to_idle   = 1'b0;
        bclk_fall = (state != IDLE) && BClk && (div == DIV_TOP);
        unique case (state)
            IDLE: begin
                if (Enable) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                launch = bclk_fall;
                if (!Enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bclk_fall && (b == LAST_B) && !Enable) begin
                    state_nxt = IDLE;
                    to_idle   = 1'b1;
                end else begin
                    launch = bclk_fall;
                    if (Enable) state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        b_nxt = '0;
        if ((state != IDLE) && (b != LAST_B)) b_nxt = b + 1'b1;
        frame_launch = launch && (b_nxt == '0);

        left_src  = left_sr;
        right_src = right_sr;
        if (frame_launch) begin
            left_src  = pop ? head[2*DATA_W-1:DATA_W] : '0;
            right_src = pop ? head[DATA_W-1:0]        : '0;
        end

        slot_r = (b_nxt >= SLOT_B);
        k      = slot_r ? (b_nxt - SLOT_B) : b_nxt;
        if (LJ_MODE) bit_on = (k < DATA_B);
        else         bit_on = (k != '0) && (k <= DATA_B);

        left_nxt  = left_src;
        right_nxt = right_src;
        sdata_bit = 1'b0;
        if (bit_on) begin
            if (slot_r) begin
                sdata_bit = right_src[DATA_W-1];
                right_nxt = right_src << 1;
            end else begin
                sdata_bit = left_src[DATA_W-1];
                left_nxt  = left_src << 1;
            end
        end
    end

    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            In_Ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_TOP) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_TOP) ? '0 : rd_ptr + 1'b1;
            level    <= level_nxt;
            In_Ready <= (level_nxt != FULL_LVL);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_n && push) mem[wr_ptr] <= In_Data;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reset_outputs();
        end else begin
            Underrun <= frame_launch && fifo_empty;
            if (to_idle) begin
                div   <= '0;
                b     <= '0;
                BClk  <= 1'b0;
                LRClk <= LR_IDLE;
                SData <= 1'b0;
            end else if (state == IDLE) begin
                div  <= '0;
                BClk <= 1'b0;
            end else if (div == DIV_TOP) begin
                div  <= '0;
                BClk <= ~BClk;
            end else begin
                div <= div + 1'b1;
            end
            if (launch) begin
                b        <= b_nxt;
                LRClk    <= slot_r ^ LJ_MODE;
                SData    <= sdata_bit;
                left_sr  <= left_nxt;
                right_sr <= right_nxt;
            end
        end
    end

    task automatic state_reset_outputs();
        div      <= '0;
        b        <= '0;
        BClk     <= 1'b0;
        LRClk    <= LR_IDLE;
        SData    <= 1'b0;
        Underrun <= 1'b0;
        left_sr  <= '0;
        right_sr <= '0;
    endtask

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Bench for i2s_stereo_tx: cycle-count reference model of the serial
// frame timing and FIFO occupancy, checked every Clk cycle.
module tb_i2s_stereo_tx;
    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int DEPTH = 8;
    localparam int DIV   = 2;
    localparam int P     = 2 * DIV;
    localparam int FRAME = 2 * SW * P;
`ifdef LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    logic                          Clk = 1'b0;
    logic                          Reset_n = 1'b0;
    logic                          Enable = 1'b0;
    logic                          In_Valid = 1'b0;
    logic [2*DW-1:0]               In_Data = '0;
    logic                          In_Ready;
    logic [$clog2(DEPTH+1)-1:0]    Fifo_Level;
    logic                          BClk, LRClk, SData, Underrun;
    logic [1:0]                    State_Dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [2*DW-1:0] mq[$];
    logic [2*DW-1:0] cur = '0;
    bit m_run = 0, m_drain = 0, m_under = 0;
    int c = 0;

    i2s_stereo_tx #(
        .DATA_W(DW), .SLOT_W(SW), .FIFO_DEPTH(DEPTH), .BCLK_DIV(DIV)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Fifo_Level(Fifo_Level), .BClk(BClk), .LRClk(LRClk),
        .SData(SData), .Underrun(Underrun), .State_Dbg(State_Dbg)
    );

    always #5 Clk = ~Clk;

    function automatic logic exp_sdata(logic [2*DW-1:0] f, int bb);
        int k = bb % SW;
        logic [DW-1:0] s = (bb < SW) ? f[2*DW-1:DW] : f[DW-1:0];
        if (LJ) return (k < DW) ? s[DW-1-k] : 1'b0;
        return (k >= 1 && k <= DW) ? s[DW-k] : 1'b0;
    endfunction

    // Model of one rising edge, using the inputs as they stood before it.
    task automatic step();
        bit ready_b = (mq.size() < DEPTH);
        bit lf = 0;
        m_under = 0;
        if (!Reset_n) begin
            mq.delete();
            m_run = 0;
            m_drain = 0;
            cur = '0;
            return;
        end
        if (!m_run) begin
            if (Enable) begin
                m_run = 1;
                c = 0;
                lf = 1;
            end
        end else begin
            c++;
            if (c % FRAME == 0) begin
                if (m_drain && !Enable) m_run = 0;
                else lf = 1;
            end
        end
        m_drain = m_run && !Enable;
        if (lf) begin
            if (mq.size() > 0) cur = mq.pop_front();
            else begin
                cur = '0;
                m_under = 1;
            end
        end
        if (In_Valid && ready_b) mq.push_back(In_Data);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = c / P;
        int bb = n % (2 * SW);
        chk("in_ready", 32'(In_Ready), 32'(mq.size() < DEPTH));
        chk("fifo_level", 32'(Fifo_Level), 32'(mq.size()));
        chk("underrun", 32'(Underrun), 32'(m_under));
        chk("state", 32'(State_Dbg), !m_run ? 32'd0 : (m_drain ? 32'd2 : 32'd1));
        if (m_run) begin
            chk("bclk", 32'(BClk), 32'((c / DIV) % 2));
            chk("lrclk", 32'(LRClk), 32'((bb >= SW) ^ LJ));
            chk("sdata", 32'(SData), 32'(exp_sdata(cur, bb)));
        end else begin
            chk("bclk_idle", 32'(BClk), 32'd0);
            chk("lrclk_idle", 32'(LRClk), 32'(!LJ));
            chk("sdata_idle", 32'(SData), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        step();
        @(negedge Clk);
        check_all();
    endtask

    task automatic wait_bit(int bb, int budget);
        int i = 0;
        while (!(m_run && (c % FRAME) == bb * P) && i < budget) begin
            tick();
            i++;
        end
        vectors++;
        assert (i < budget) else begin
            miscompares++;
            $error("FAIL wait_bit: observed timeout %0d expected bit %0d", i, bb);
        end
    endtask

    task automatic wait_idle(int budget);
        int i = 0;
        while (m_run && i < budget) begin
            tick();
            i++;
        end
        vectors++;
        assert (State_Dbg === 2'd0) else begin
            miscompares++;
            $error("FAIL wait_idle: observed %0d expected 0", State_Dbg);
        end
    endtask

    function automatic logic [2*DW-1:0] rnd_frame();
        return (2*DW)'({$urandom(), $urandom()});
    endfunction

    initial begin
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();

        In_Valid = 1'b1;
        In_Data  = {24'hA5A5A5, 24'h5A5A5A};
        tick();
        In_Valid = 1'b0;
        chk("level_one", 32'(Fifo_Level), 32'd1);
        Enable = 1'b1;
        tick();
        chk("level_entry", 32'(Fifo_Level), 32'd0);
        chk("lrclk_entry", 32'(LRClk), 32'(LJ));
        repeat (2 * FRAME + 8) tick();

        for (int i = 0; i < 3; i++) begin
            In_Valid = 1'b1;
            In_Data  = rnd_frame();
            tick();
        end
        In_Valid = 1'b0;
        wait_bit(10, 2 * FRAME);
        Enable = 1'b0;
        wait_idle(2 * FRAME);
        repeat (20) tick();

        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        In_Valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            In_Data = rnd_frame();
            tick();
        end
        In_Valid = 1'b0;
        chk("full_level", 32'(Fifo_Level), 32'(DEPTH));
        chk("full_ready", 32'(In_Ready), 32'd0);
        Enable = 1'b1;
        tick();
        tick();
        chk("ready_after_pop", 32'(In_Ready), 32'd1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            In_Valid = ($urandom_range(0, 7) == 0);
            In_Data  = rnd_frame();
            tick();
        end
        In_Valid = 1'b0;
        Enable = 1'b0;
        wait_idle(3 * FRAME);

        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        In_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            In_Data = rnd_frame();
            tick();
        end
        In_Valid = 1'b0;
        Enable = 1'b1;
        wait_bit(40, 2 * FRAME);
        chk("queued_three", 32'(Fifo_Level), 32'd3);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        Enable = 1'b0;
        chk("reset_level", 32'(Fifo_Level), 32'd0);
        chk("reset_ready", 32'(In_Ready), 32'd1);
        repeat (5) tick();

        for (int i = 0; i < 3000; i++) begin
            In_Valid = ($urandom_range(0, 5) == 0);
            In_Data  = rnd_frame();
            if ($urandom_range(0, 199) == 0) Enable = ~Enable;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2s_stereo_tx.md
Name: i2s_stereo_tx

Overview:
- Parametrised stereo I2S transmitter; successor to the fixed 24-bit audio serialiser.
- Generates its own BClk and LRClk from the single system clock.
- Buffers stereo frames in an internal FIFO with a valid/ready handshake, and reports FIFO underrun.
- Sits between the sample source (SRAM/SD reader) and the external audio codec DAC input.

Parameters:
- DATA_W, 24: sample width per channel; must satisfy 1 <= DATA_W <= SLOT_W-1.
- SLOT_W, 32: BClk periods per channel slot; frame is 2*SLOT_W bits.
- FIFO_DEPTH, 8: stereo frames buffered; must be >= 2.
- BCLK_DIV, 2: Clk cycles per BClk half-period; must be >= 1. Bit period is 2*BCLK_DIV Clk cycles.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Enable  in  1  run request for the serial interface.
- In_Valid  in  1  In_Data holds a frame.
- In_Data  in  2*DATA_W  {left, right}; left occupies the upper DATA_W bits.
- In_Ready  out  1  FIFO can accept a frame (registered, equals !full).
- Fifo_Level  out  $clog2(FIFO_DEPTH+1)  frames currently stored.
- BClk  out  1  bit clock.
- LRClk  out  1  word select; 0 = left slot, 1 = right slot.
- SData  out  1  serial data, MSB first.
- Underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- State_Dbg  out  2  current FSM state, for LEDs.

Behaviour:
- Reset: applies while Reset_n=0 at a rising Clk edge, including mid-frame. After reset:
  - state IDLE; FIFO flushed; Fifo_Level=0; In_Ready=1.
  - BClk=0, LRClk=1, SData=0, Underrun=0.
  - divider and bit counter are 0.
- FIFO:
  - A push happens when In_Valid && In_Ready.
  - A pop happens only at a frame launch (below).
  - A push and a pop in the same cycle leave Fifo_Level unchanged.
  - When the FIFO is full, In_Ready is low, so a same-cycle pop does not admit a push; In_Ready rises the cycle after the pop.
  - When the FIFO is empty, a push in the launch cycle is not bypassed: the launch underruns and the pushed frame is sent next frame.
- FSM states:
  - IDLE (0): BClk=0, LRClk=1, SData=0. Enable=1 goes to RUN.
  - RUN (1): serialises frames continuously. Enable=0 goes to DRAIN.
  - DRAIN (2): finishes the current frame. At the launch event that would start the next bit 0, goes to IDLE instead of launching. Enable=1 during DRAIN returns to RUN with no gap.
- Launch events:
  - One occurs in the IDLE->RUN transition cycle.
  - One occurs on every Clk edge where BClk transitions 1->0.
  - BClk toggles every BCLK_DIV Clk cycles while in RUN/DRAIN; the divider restarts at 0 on RUN entry.
- Bit counter b (0..2*SLOT_W-1):
  - Set to 0 on RUN entry; advances by 1 at each subsequent launch, wrapping 2*SLOT_W-1 -> 0.
  - LRClk = (b >= SLOT_W), registered at the launch.
- Frame launch (b becomes 0):
  - FIFO non-empty: pop into the left and right shift registers.
  - FIFO empty: load zeros and pulse Underrun for exactly one Clk cycle.
- SData for slot offset k = b mod SLOT_W (I2S mode):
  - k=0: 0.
  - k=1..DATA_W: sample bit DATA_W-k (MSB first).
  - k>DATA_W: 0.
- Latency: first MSB appears on SData at the second launch after RUN entry, i.e. 2*BCLK_DIV Clk cycles after entry.
- Output timing: SData, LRClk and BClk are registers, so the codec samples them on the BClk rising edge, mid-bit.

Optional Feature:
- Macro LEFT_JUSTIFIED_EN.
- Defined: left-justified format.
  - MSB appears at k=0; bit DATA_W-1-k is sent for k=0..DATA_W-1; 0 thereafter.
  - LRClk polarity is inverted (1 = left); LRClk reset/idle value is 0.
  - The DATA_W constraint relaxes to 1 <= DATA_W <= SLOT_W.
- Undefined: standard I2S as specified above.

Test Plan:
- Defaults, push one frame {L=24'hA5A5A5, R=24'h5A5A5A}, then Enable=1:
  - LRClk falls at entry.
  - SData bits 1..24 = A5A5A5 MSB-first; bits 25..31 = 0.
  - LRClk=1 for bits 32..63; R sent at bits 33..56.
  - Fifo_Level 1->0 at entry.
- Continue from the above with no further pushes: Underrun pulses one cycle at the next launch (256 Clk after entry), and the all-zero frame is sent.
- Enable=0, push 9 frames back-to-back: In_Ready low after the 8th push; Fifo_Level=8; the 9th frame is not accepted. Then Enable=1: In_Ready returns the cycle after the first pop.
- Deassert Enable at bit 10 of a frame: the frame completes to bit 63, then IDLE with BClk=0, LRClk=1, SData=0; the next FIFO entry is not popped.
- Reset_n=0 for one cycle at bit 40 with 3 frames queued: next cycle shows IDLE, Fifo_Level=0, In_Ready=1, BClk=0, LRClk=1, SData=0.
- With LEFT_JUSTIFIED_EN, BCLK_DIV=1, DATA_W=32, SLOT_W=32, L=32'h80000001: SData=1 at k=0 and k=31 of the left slot, with LRClk=1.
